// File: rtl/uart_transceiver_pkg.sv
// Shared types and constants for the 8N1 UART transmit and receive engines.
// Holds the engine state encodings, frame constants and the divider helper.
// Both engines and the top level import this package.
package uart_transceiver_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clocks per serial bit; integer division truncates toward zero.
  function automatic int calc_div(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_transceiver_rx.sv
// Receive engine: synchronises rx, finds the start edge, samples mid-bit, checks the stop bit.
// Latency: 2 sync clocks + 1 edge-detect clock + DIV/2 to start check, then DIV per bit.
// Backpressure: none; a new good frame overwrites data_o, done_o is a level the host polls.
module uart_rx_engine
  import uart_transceiver_pkg::*;
#(
  parameter int DIV = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       done_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((DIV / 2) - 1);

  logic             meta_q;
  logic             sync_q;
  logic             prev_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             fall_edge;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Only a high-to-low edge arms the receiver, so after a framing error
  // the line must return high before the next frame can start.
  assign fall_edge = prev_q & ~sync_q;

  // Frame sampler; done_q is cleared only once a start bit is confirmed so a glitch leaves it intact.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (fall_edge) begin
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (sync_q == START_BIT) begin
              done_q  <= 1'b0;
              state_q <= RX_DATA;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {sync_q, shreg_q[7:1]};
            if (bit_q == 3'(DATA_BITS - 1)) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync_q == STOP_BIT) begin
              data_q <= shreg_q;
              done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data_o = data_q;
  assign done_o = done_q;

endmodule

// File: rtl/uart_transceiver_tx.sv
// Transmit engine: serialises one latched byte as start, 8 data (LSB first), stop.
// Latency: tx falls one clock after start_i is accepted; done_o rises 10*DIV clocks after acceptance.
// Backpressure: start_i is only accepted in IDLE; requests during a frame are dropped.
module uart_tx_engine
  import uart_transceiver_pkg::*;
#(
  parameter int DIV = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic             tx_q;
  logic             done_q;
  logic             bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  // Frame sequencer; tx_q is driven from the current state so every level lasts DIV clocks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= STOP_BIT;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q  <= STOP_BIT;
          cnt_q <= '0;
          bit_q <= '0;
          if (start_i) begin
            shreg_q <= data_i;
            done_q  <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          tx_q <= START_BIT;
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          tx_q <= shreg_q[0];
          if (bit_end) begin
            cnt_q   <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_q == 3'(DATA_BITS - 1)) begin
              state_q <= TX_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          tx_q <= STOP_BIT;
          if (bit_end) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign done_o = done_q;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmit and receive engines sharing one clock divider ratio.
// Latency: see the engines; the top adds no registers.
// Backpressure: start_tx is ignored while a frame is in flight; completion flags are held levels.
module uart_transceiver
  import uart_transceiver_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data_in,
  input  logic       start_tx,
  output logic       tx_done,
  output logic [7:0] rx_data_out,
  output logic       rx_done
);

  localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);

  uart_tx_engine #(.DIV(DIV)) u_tx (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start_tx),
    .data_i  (tx_data_in),
    .tx_o    (tx),
    .done_o  (tx_done)
  );

  uart_rx_engine #(.DIV(DIV)) u_rx (
    .clk_i  (clk),
    .rst_i  (rst),
    .rx_i   (rx),
    .data_o (rx_data_out),
    .done_o (rx_done)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver with a reduced divider (16 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_transceiver;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b1;
  logic       tx;
  logic [7:0] tx_data_in = 8'h00;
  logic       start_tx = 1'b0;
  logic       tx_done;
  logic [7:0] rx_data_out;
  logic       rx_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] tx_byte;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl[5];

  assign rx_line = loopback ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver #(.BAUD_RATE(10000), .CLOCK_FREQ(160000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx_line),
    .tx          (tx),
    .tx_data_in  (tx_data_in),
    .start_tx    (start_tx),
    .tx_done     (tx_done),
    .rx_data_out (rx_data_out),
    .rx_done     (rx_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for tx_done; returns clocks elapsed since the call.
  task automatic wait_tx_done(output int cyc);
    cyc = 0;
    while (tx_done !== 1'b1 && cyc < 12 * DIV) begin
      step();
      cyc++;
    end
  endtask

  // Issues one start pulse in loopback and checks timing plus the received byte.
  task automatic send_check(input string name, input logic [7:0] b, input logic [7:0] exp);
    int cyc;
    tx_data_in = b;
    start_tx   = 1'b1;
    step();
    start_tx   = 1'b0;
    chk({name, "_done_clr"}, 32'(tx_done), 32'd0);
    cyc = 0;
    while (tx_done !== 1'b1 && cyc < 12 * DIV) begin
      step();
      cyc++;
      if (cyc == 2 * DIV) chk({name, "_rxdone_clr"}, 32'(rx_done), 32'd0);
    end
    chk({name, "_done_lat"}, 32'(cyc), 32'(10 * DIV));
    chk({name, "_rx_done"}, 32'(rx_done), 32'd1);
    chk({name, "_rx_data"}, 32'(rx_data_out), 32'(exp));
  endtask

  // Bit-bangs one frame onto rx with a chosen stop-bit level.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = frame[k];
      repeat (DIV) step();
    end
  endtask

  initial begin
    int cyc;
    logic [9:0] frame;

    tbl[0] = '{tx_byte: 8'h00, exp_rx: 8'h00};
    tbl[1] = '{tx_byte: 8'hFF, exp_rx: 8'hFF};
    tbl[2] = '{tx_byte: 8'h81, exp_rx: 8'h81};
    tbl[3] = '{tx_byte: 8'h5A, exp_rx: 8'h5A};
    tbl[4] = '{tx_byte: 8'h01, exp_rx: 8'h01};

    // Reset state
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_rx_data", 32'(rx_data_out), 32'h00);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    rst = 1'b0;
    repeat (4) step();

    // Exact bit-level waveform for 8'hA5 in loopback
    tx_data_in = 8'hA5;
    start_tx   = 1'b1;
    step();
    start_tx   = 1'b0;
    tx_data_in = 8'h00;
    chk("a5_tx_pre", 32'(tx), 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 1; c <= 10 * DIV; c++) begin
      int k;
      step();
      k = (c - 1) / DIV;
      if (c == k * DIV + 1) chk($sformatf("a5_bit%0d_first", k), 32'(tx), 32'(frame[k]));
      if (c == (k + 1) * DIV) chk($sformatf("a5_bit%0d_last", k), 32'(tx), 32'(frame[k]));
      if (c == 10 * DIV - 1) chk("a5_done_early", 32'(tx_done), 32'd0);
      if (c == 10 * DIV) chk("a5_done", 32'(tx_done), 32'd1);
    end
    chk("a5_rx_done", 32'(rx_done), 32'd1);
    chk("a5_rx_data", 32'(rx_data_out), 32'hA5);

    // Back-to-back table: each start issued the cycle after tx_done rises
    for (int i = 0; i < 5; i++) begin
      send_check($sformatf("vec%0d", i), tbl[i].tx_byte, tbl[i].exp_rx);
    end

    // Start request mid-frame must be ignored
    repeat (4) step();
    tx_data_in = 8'h00;
    start_tx   = 1'b1;
    step();
    start_tx   = 1'b0;
    repeat (3 * DIV) step();
    tx_data_in = 8'h3C;
    start_tx   = 1'b1;
    step();
    start_tx   = 1'b0;
    tx_data_in = 8'hFF;
    wait_tx_done(cyc);
    chk("ign_done_lat", 32'(cyc), 32'(10 * DIV - 3 * DIV - 1));
    chk("ign_rx_data", 32'(rx_data_out), 32'h00);
    repeat (12 * DIV) step();
    chk("ign_tx_idle", 32'(tx), 32'd1);
    chk("ign_done_hold", 32'(tx_done), 32'd1);
    chk("ign_rx_keep", 32'(rx_data_out), 32'h00);
    chk("ign_rx_done_keep", 32'(rx_done), 32'd1);

    // Glitch shorter than half a bit: nothing happens
    rx_drv   = 1'b1;
    loopback = 1'b0;
    repeat (4) step();
    rx_drv = 1'b0;
    repeat (5) step();
    rx_drv = 1'b1;
    repeat (3 * DIV) step();
    chk("glitch_rx_done", 32'(rx_done), 32'd1);
    chk("glitch_rx_data", 32'(rx_data_out), 32'h00);

    // Framing error, then a valid frame
    drive_frame(8'h55, 1'b0);
    rx_drv = 1'b0;
    repeat (DIV) step();
    chk("ferr_rx_done", 32'(rx_done), 32'd0);
    chk("ferr_rx_data", 32'(rx_data_out), 32'h00);
    rx_drv = 1'b1;
    repeat (2 * DIV) step();
    chk("ferr_rearm_data", 32'(rx_data_out), 32'h00);
    drive_frame(8'h12, 1'b1);
    rx_drv = 1'b1;
    repeat (2) step();
    chk("after_ferr_done", 32'(rx_done), 32'd1);
    chk("after_ferr_data", 32'(rx_data_out), 32'h12);

    // Reset mid-transmission
    loopback = 1'b1;
    repeat (2 * DIV) step();
    tx_data_in = 8'hF0;
    start_tx   = 1'b1;
    step();
    start_tx   = 1'b0;
    repeat (4 * DIV) step();
    chk("midrst_tx_low", 32'(tx), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_tx_done", 32'(tx_done), 32'd0);
    chk("midrst_rx_done", 32'(rx_done), 32'd0);
    chk("midrst_rx_data", 32'(rx_data_out), 32'h00);
    repeat (DIV) step();
    chk("midrst_tx_quiet", 32'(tx), 32'd1);
    send_check("post_rst", 8'h81, 8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
